mem_fill_arbiter: RTL
=====================

# mem_fill_arbiter

Sits between the CPU's instruction/data caches and the single shared multi-cycle main memory. Arbitrates instruction-cache misses, data-cache load misses and write-through stores onto one memory port. Performs 16-byte (8-word) block fills, streaming each returned word back to the requesting cache. Produces the stall signals that freeze the pipeline while a miss is serviced.

## Interface
Parameters:
- MEM_LAT, 4: cycles from a memory read issue to its `mem_valid`/`mem_rdata` return; reads are pipelined, one issue per cycle.
- WORDS, 8: 16-bit words per cache block. Block base = addr & 16'hFFF0.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- i_miss  in  1  instruction cache miss, held until `i_fill_done`.
- i_miss_addr  in  16  instruction miss byte address.
- d_miss  in  1  data cache load miss, held until `d_fill_done`.
- d_miss_addr  in  16  data miss byte address.
- d_wr  in  1  store request (write-through, no allocate).
- d_wr_addr  in  16  store byte address.
- d_wr_data  in  16  store data.
- mem_en  out  1  memory access enable.
- mem_wr  out  1  memory write (valid with `mem_en`).
- mem_addr  out  16  memory byte address.
- mem_wdata  out  16  memory write data.
- mem_rdata  in  16  memory read data.
- mem_valid  in  1  `mem_rdata` valid.
- fill_data  out  16  returned word, registered copy of `mem_rdata`.
- fill_word  out  3  word index within block.
- fill_base  out  16  block base address, used for tag write.
- i_fill_we  out  1  write `fill_data` into the I-cache data array.
- d_fill_we  out  1  write `fill_data` into the D-cache data array.
- i_fill_done  out  1  one-cycle pulse: I block complete, write tag/valid.
- d_fill_done  out  1  one-cycle pulse: D block complete, write tag/valid.
- i_stall  out  1  instruction side must stall.
- d_stall  out  1  data side must stall.

## Operation
- States: IDLE, ISSUE, DRAIN, DONE. Owner register `own_d` records whether the fill serves D (1) or I (0).
- Arbitration in IDLE uses fixed priority: d_wr > d_miss > i_miss. The data side is older in the pipeline.
- Store in IDLE:
  - Drive mem_en=1, mem_wr=1, mem_addr=d_wr_addr, mem_wdata=d_wr_data combinationally in the same cycle.
  - State stays IDLE. Any pending miss is taken the following cycle.
- Miss in IDLE:
  - Latch base=addr&FFF0 and own_d. Clear issue counter `icnt` and receive counter `rcnt`. Go to ISSUE.
- ISSUE:
  - Each cycle drive mem_en=1, mem_wr=0, mem_addr=base+2*icnt, then icnt++.
  - After issuing icnt=WORDS-1, go to DRAIN.
- ISSUE/DRAIN receive path:
  - On each mem_valid, register fill_data=mem_rdata and fill_word=rcnt. Pulse i_fill_we or d_fill_we per own_d for one cycle. Then rcnt++.
  - When the 8th word is received, go to DONE.
- DONE:
  - Pulse i_fill_done or d_fill_done for one cycle. Go to IDLE.
- Stalls:
  - d_stall = (d_wr & state!=IDLE) | (d_miss & ~d_fill_done).
  - i_stall = i_miss & ~i_fill_done.
  - A store that arrives while a fill is active waits, stalled, until IDLE.
- Counters are 3-bit and wrap. Address arithmetic is mod 2^16; base+14 never crosses a block.
- mem_valid outside ISSUE/DRAIN, or after rcnt has wrapped, is ignored.

## Timing
- Reset values: all outputs 0. Internal state: IDLE, counters 0, base 0, own_d 0.
- Miss seen in IDLE at cycle 0:
  - Reads issue in cycles 1..8.
  - Data returns in cycles 1+MEM_LAT..8+MEM_LAT.
  - fill_we pulses in cycles 2+MEM_LAT..9+MEM_LAT, one cycle after each return because fill_data is registered.
  - fill_done in cycle 10+MEM_LAT, which is 14 for MEM_LAT=4. IDLE in cycle 15.
- Back-to-back: a miss already asserted when the block returns to IDLE is taken in that IDLE cycle, with no bubble beyond the IDLE cycle.
- Reset asserted mid-fill:
  - Next cycle is IDLE with no fill_we/done.
  - A discard counter then ignores mem_valid for MEM_LAT cycles, so stale in-flight reads are never written into a cache.
- Simultaneous d_miss and i_miss: D is served first. i_stall stays high throughout both fills.

## Structure
- Package `mem_arb_pkg`: state enum, BLOCK_MASK=16'hFFF0, default MEM_LAT/WORDS.
- No sub-module: FSM, two counters, discard counter and output registers in one module.

## Test plan
- Lone I miss, addr 16'h0046, memory word at A = A^16'hA5A5:
  - Reads issue at 0x40..0x4E in cycles 1..8.
  - i_fill_we pulses 6..13 with words 0..7 and correct data.
  - i_fill_done at 14, fill_base 0x0040. i_stall low from cycle 14.
- d_miss and i_miss asserted in the same cycle:
  - D fill completes first (d_fill_done at 14).
  - I fill starts cycle 15; i_fill_done at 29.
- d_wr (0x1002, 0xBEEF) in IDLE:
  - mem_en=mem_wr=1 the same cycle, no stall.
  - A subsequent read of 0x1002 returns 0xBEEF.
- d_wr arriving in cycle 3 of an I fill:
  - d_stall high until IDLE, then write issued.
  - Fill data uncorrupted.
- rst_n low for 1 cycle at cycle 7 of a fill:
  - No further fill_we/fill_done.
  - The next miss fills correctly with no stale words.
- Eight consecutive misses alternating I/D: every fill_word sequence is 0..7 and counters wrap cleanly.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the cache-fill / store arbiter onto main memory.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [15:0] BLOCK_MASK  = 16'hFFF0;
  localparam int          DEF_MEM_LAT = 4;
  localparam int          DEF_WORDS   = 8;

endpackage

// File: rtl/mem_fill_arbiter.sv
// Arbitrates I-miss, D-miss and write-through stores onto one pipelined memory port
// and streams 8-word block fills back to the requesting cache.
//
// state | meaning
// IDLE  | stores pass through combinationally; misses accepted (d_wr > d_miss > i_miss)
// ISSUE | one block read issued per cycle, returns collected in parallel
// DRAIN | all reads issued, collecting remaining returns
// DONE  | one-cycle fill_done pulse to the owning cache
module mem_fill_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int WORDS   = DEF_WORDS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_miss,
  input  logic [15:0] i_miss_addr,
  input  logic        d_miss,
  input  logic [15:0] d_miss_addr,
  input  logic        d_wr,
  input  logic [15:0] d_wr_addr,
  input  logic [15:0] d_wr_data,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_base,
  output logic        i_fill_we,
  output logic        d_fill_we,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        i_stall,
  output logic        d_stall
);

  localparam int CW = $clog2(WORDS);
  localparam int DW = $clog2(MEM_LAT + 1);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t        state, state_nxt;
  logic          own_d;
  logic [15:0]   base;
  logic [CW-1:0] icnt, rcnt;
  logic          rx_full;
  logic [DW-1:0] disc;
  logic          accept, rx;

  assign accept = (state == ST_IDLE) && !d_wr && (d_miss || i_miss);
  // Returns are dropped while reads issued before a reset may still be in flight.
  assign rx = ((state == ST_ISSUE) || (state == ST_DRAIN)) && mem_valid &&
              (disc == '0) && !rx_full;

  always_comb begin
    state_nxt = state;
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = 16'h0000;
    mem_wdata = 16'h0000;
    case (state)
      ST_IDLE: begin
        if (d_wr) begin
          mem_en    = 1'b1;
          mem_wr    = 1'b1;
          mem_addr  = d_wr_addr;
          mem_wdata = d_wr_data;
        end else if (d_miss || i_miss) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = base + 16'({icnt, 1'b0});
        if (icnt == LAST) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (rx_full) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      own_d     <= 1'b0;
      base      <= 16'h0000;
      icnt      <= '0;
      rcnt      <= '0;
      rx_full   <= 1'b0;
      disc      <= DW'(MEM_LAT);
      fill_data <= 16'h0000;
      fill_word <= 3'd0;
      i_fill_we <= 1'b0;
      d_fill_we <= 1'b0;
    end else begin
      state     <= state_nxt;
      i_fill_we <= 1'b0;
      d_fill_we <= 1'b0;
      if (disc != '0) disc <= disc - DW'(1);
      if (accept) begin
        own_d   <= d_miss;
        base    <= (d_miss ? d_miss_addr : i_miss_addr) & BLOCK_MASK;
        icnt    <= '0;
        rcnt    <= '0;
        rx_full <= 1'b0;
      end
      if (state == ST_ISSUE) icnt <= icnt + CW'(1);
      if (rx) begin
        fill_data <= mem_rdata;
        fill_word <= 3'(rcnt);
        i_fill_we <= ~own_d;
        d_fill_we <= own_d;
        rcnt      <= rcnt + CW'(1);
        if (rcnt == LAST) rx_full <= 1'b1;
      end
    end
  end

  assign fill_base   = base;
  assign i_fill_done = (state == ST_DONE) && !own_d;
  assign d_fill_done = (state == ST_DONE) && own_d;
  assign i_stall     = i_miss && !i_fill_done;
  assign d_stall     = (d_wr && (state != ST_IDLE)) || (d_miss && !d_fill_done);

endmodule
